// File: rtl/out_io_pkg.sv
// Shared constants and helpers for the CPU output-port receiver.
// Holds the default FIFO geometry and the pointer-width function.
package out_io_pkg;

    localparam int OUT_IO_DEPTH  = 8;
    localparam int OUT_IO_DATA_W = 8;

    // A depth-1 FIFO still needs a 1-bit pointer so the port widths stay legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/out_io_fifo_mem.sv
// DEPTH x DATA_W register array for the output-port FIFO.
// Synchronous write port, asynchronous read port; contents survive reset.
module out_io_fifo_mem
    import out_io_pkg::*;
#(
    parameter int DEPTH  = OUT_IO_DEPTH,
    parameter int DATA_W = OUT_IO_DATA_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ptr_w(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_io_receiver.sv
// Receiver for the CPU 8-bit output port: buffers each write strobe in a
// first-word-fall-through FIFO drained over valid/ready. Optional OUT_IO_RX_DEDUP_EN drops repeated bytes.
module out_io_receiver
    import out_io_pkg::*;
#(
    parameter int DEPTH  = OUT_IO_DEPTH,
    parameter int DATA_W = OUT_IO_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   io_we,
    input  logic [DATA_W-1:0]      io_data,
    input  logic                   rd_ready,
    input  logic                   clr_ovf,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [ptr_w(DEPTH):0]  count,
    output logic                   overflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [DATA_W-1:0] mem_rdata;

    logic full;
    logic empty;
    logic pop;
    logic cand;
    logic push;
    logic drop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign pop   = !empty && rd_ready;

`ifdef OUT_IO_RX_DEDUP_EN
    logic [DATA_W-1:0] last_q;
    logic              last_vld;
    logic              dup;

    // last_vld makes the very first write after reset pass even if it is zero.
    assign dup  = last_vld && (io_data == last_q);
    assign cand = io_we && !dup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= '0;
            last_vld <= 1'b0;
        end else if (push) begin
            last_q   <= io_data;
            last_vld <= 1'b1;
        end
    end
`else
    assign cand = io_we;
`endif

    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    out_io_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (io_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Memory is not cleared by reset, so the head is masked while empty.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_rdata;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_out_io_receiver.sv
// Self-checking bench for out_io_receiver: directed scenarios plus randomized
// traffic against a queue-based reference model (honours OUT_IO_RX_DEDUP_EN).
module tb_out_io_receiver;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              io_we;
    logic [DATA_W-1:0] io_data;
    logic              rd_ready;
    logic              clr_ovf;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        count;
    logic              overflow;

    int n_tests;
    int n_fail;

    // Reference model state
    int       q[$];
    bit       m_ovf;
    bit       m_have_last;
    int       m_last;

    out_io_receiver #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_we    (io_we),
        .io_data  (io_data),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf       = 1'b0;
        m_have_last = 1'b0;
        m_last      = 0;
    endtask

    task automatic model_edge(input bit we, input int d, input bit rdy, input bit clr);
        bit pop, cand, full, push, drop;
        pop  = (q.size() > 0) && rdy;
        cand = we;
`ifdef OUT_IO_RX_DEDUP_EN
        if (we && m_have_last && d == m_last) cand = 1'b0;
`endif
        full = (q.size() == DEPTH);
        push = cand && (!full || pop);
        drop = cand && full && !pop;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(d);
            m_last      = d;
            m_have_last = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_state();
        chk("count", int'(count), q.size());
        chk("rd_valid", int'(rd_valid), (q.size() != 0) ? 1 : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
        if (q.size() != 0) chk("head", int'(rd_data), q[0]);
    endtask

    // Drive at the falling edge, check the popped head just before the rising
    // edge, then check the registered state on the next falling edge.
    task automatic step(input bit we, input int d, input bit rdy, input bit clr);
        io_we    = we;
        io_data  = d[DATA_W-1:0];
        rd_ready = rdy;
        clr_ovf  = clr;
        #1;
        if (rdy && q.size() != 0) chk("pop_data", int'(rd_data), q[0]);
        @(posedge clk);
        model_edge(we, d, rdy, clr);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        io_we = 1'b0; io_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        io_we = 1'b0; io_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three strobes, then drain
        step(1, 'h11, 0, 0);
        step(1, 'h22, 0, 0);
        step(1, 'h33, 0, 0);
        chk("t1_count", int'(count), 3);
        chk("t1_head", int'(rd_data), 'h11);
        step(0, 0, 1, 0);
        chk("t1_pop1", int'(rd_data), 'h22);
        step(0, 0, 1, 0);
        chk("t1_pop2", int'(rd_data), 'h33);
        step(0, 0, 1, 0);
        chk("t1_empty", int'(rd_valid), 0);

        // Fill, overflow, drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0);
        step(1, 'h08, 0, 0);
        chk("t2_ovf", int'(overflow), 1);
        chk("t2_count", int'(count), DEPTH);
        chk("t2_head", int'(rd_data), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        chk("t2_empty", int'(rd_valid), 0);
        step(0, 0, 0, 1);
        chk("t2_clr", int'(overflow), 0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0);
        step(1, 'hAA, 1, 0);
        chk("t3_count", int'(count), DEPTH);
        chk("t3_ovf", int'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        chk("t3_empty", int'(rd_valid), 0);

        // Continuous streaming, pointers wrap
        do_reset();
        for (int i = 0; i < 20; i++) step(1, i, 1, 0);
        step(0, 0, 1, 0);
        chk("t4_ovf", int'(overflow), 0);
        chk("t4_empty", int'(rd_valid), 0);

        // Asynchronous reset mid-cycle with five entries held
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 'h30 + i, 0, 0);
        chk("t5_count", int'(count), 5);
        io_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_count", int'(count), 0);
        chk("t5_rst_valid", int'(rd_valid), 0);
        chk("t5_rst_data", int'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 'h5A, 0, 0);
        chk("t5_data", int'(rd_data), 'h5A);
        chk("t5_count1", int'(count), 1);

`ifdef OUT_IO_RX_DEDUP_EN
        do_reset();
        step(1, 'h42, 0, 0);
        step(1, 'h42, 0, 0);
        step(1, 'h43, 0, 0);
        step(1, 'h42, 0, 0);
        chk("t6_count", int'(count), 3);
        step(0, 0, 1, 0);
        chk("t6_pop1", int'(rd_data), 'h43);
        step(0, 0, 1, 0);
        chk("t6_pop2", int'(rd_data), 'h42);
        step(0, 0, 1, 0);
        chk("t6_empty", int'(rd_valid), 0);
`endif

        // Randomized traffic in phases of varying push/pop pressure
        do_reset();
        for (int ph = 0; ph < 30; ph++) begin
            int we_pct, rdy_pct;
            we_pct  = $urandom_range(20, 95);
            rdy_pct = $urandom_range(5, 95);
            for (int c = 0; c < 80; c++) begin
                bit we, rdy, clr;
                int d;
                we  = ($urandom_range(0, 99) < we_pct);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                clr = ($urandom_range(0, 99) < 5);
                d   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
                step(we, d, rdy, clr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/out_io_receiver.md
# out_io_receiver

Receiving end of the CPU's 8-bit output port. It samples each output-port write strobe from `top` and buffers the byte in a small first-word-fall-through FIFO. A downstream consumer drains the FIFO over a valid/ready handshake, for example a display driver or the bench's scoreboard. The block sits beside `top`, fed by `out_io` plus a write strobe, so that bytes written in consecutive cycles are never lost.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `DATA_W`, 8: byte width; matches `out_io`.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `io_we`, input, 1: output-port write strobe from the CPU, one cycle per write.
- `io_data`, input, DATA_W: `out_io` value, valid when `io_we`=1.
- `rd_ready`, input, 1: consumer accepts the head entry.
- `clr_ovf`, input, 1: clears `overflow`.
- `rd_valid`, output, 1: FIFO non-empty; `rd_data` holds the head entry.
- `rd_data`, output, DATA_W: head of FIFO.
- `count`, output, $clog2(DEPTH)+1: current occupancy.
- `overflow`, output, 1: sticky flag; a write was dropped.

## Operation
- Reset is asynchronous on `rst_n`=0 and is not cycle-aligned. It zeroes:
  - write and read pointers
  - `count`, `overflow`, `rd_valid` and `rd_data`
  - the last-value register (when DEDUP is compiled in)
- Reset does not clear the memory contents.
- Reset mid-stream discards all buffered bytes. The first write after release lands in entry 0.
- Push happens when `io_we`=1 and one of the following holds:
  - `count`<DEPTH, or
  - `count`=DEPTH and a pop occurs in the same cycle.
- Pop happens when `rd_valid`=1 and `rd_ready`=1.
- Push and pop in the same cycle: the data moves and `count` is unchanged. This includes the full case.
- Empty with `io_we`=1 and `rd_ready`=1: no pop, because `rd_valid` is still 0. Push proceeds and `count` becomes 1.
- Full, `io_we`=1, no pop: the byte is dropped, `overflow` is set, and the FIFO contents are unchanged.
- `overflow` is cleared by `clr_ovf`=1. If an overflow and a clear happen in the same cycle, set wins.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided from `count` only.
- `rd_valid` = (`count`!=0), driven from registered state.
- `rd_data` is read from the registered head pointer. It updates the cycle after a pop, or after a push into an empty FIFO.
- `io_data` is ignored when `io_we`=0. Inputs are already in the `clk` domain, so no synchronisers are used.

## Timing
- Write latency: `io_we` sampled at edge N gives `rd_valid`=1 and `rd_data`=byte after edge N, i.e. usable from cycle N+1.
- Pop at edge M presents the next entry after edge M.
- Throughput: one push and one pop per cycle, sustained indefinitely with zero loss.
- `count`, `overflow` and `rd_valid` all change only on `clk` rising edges, except on reset.

## Configuration
- `OUT_IO_RX_DEDUP_EN` defined:
  - A last-value register holds the most recently accepted byte.
  - A write whose `io_data` equals that value is discarded. It does not push and does not set `overflow`.
  - The first write after reset is always accepted.
  - The last-value register updates only on accepted pushes.
- Macro undefined: every strobe is a push candidate, and the last-value register is not synthesised.

## Structure
- Shared package `out_io_pkg` holds:
  - the `OUT_IO_DEPTH` default (8)
  - the `OUT_IO_DATA_W` default (8)
  - a pointer-width constant function
- One sub-module, `out_io_fifo_mem`: a DEPTH×DATA_W register array with a synchronous write port and an asynchronous read port. Pointers, count, overflow and dedup logic stay in `out_io_receiver`.

## Test plan
- Reset, then three strobes 0x11, 0x22, 0x33 with `rd_ready`=0: `count`=3 and `rd_data`=0x11. Raising `rd_ready` yields 0x11, 0x22, 0x33 on consecutive cycles, then `rd_valid`=0.
- Fill to DEPTH=8 with 0x00..0x07, then strobe 0x08 without a pop: `overflow`=1 and `count`=8. The head stays 0x00, and the drain returns 0x00..0x07 only.
- Full FIFO, `io_we`=1 with 0xAA and `rd_ready`=1 in the same cycle: the pop returns 0x00, `count` stays 8, and 0xAA is the last entry.
- Continuous strobes 0x00..0x13 (20 bytes) with `rd_ready`=1 throughout: output matches input in order, pointers wrap twice, and `overflow` stays 0.
- Assert `rst_n`=0 mid-cycle with `count`=5: outputs go 0 immediately. After release, strobe 0x5A, and `rd_data`=0x5A with `count`=1.
- With `OUT_IO_RX_DEDUP_EN` defined, strobe 0x42, 0x42, 0x43, 0x42: `count`=3 and the drain gives 0x42, 0x43, 0x42.
